// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS execute path: ALU op codes, datapath default width,
// and the multiplier FSM state type (used only when MULT_EN is defined).
package cpu_pkg;

  localparam int CPU_WIDTH = 32;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLT_I = 4'b1111;
  localparam logic [3:0] ALU_MUL   = 4'b1000;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_t;

endpackage

// File: rtl/mult_iter.sv
// Iterative shift-add unsigned multiplier returning the low WIDTH bits after WIDTH cycles.
// Instantiated by ex_stage only when MULT_EN is defined.
module mult_iter
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  mul_state_t       state, state_nx;
  logic [WIDTH-1:0] acc_p1, mcand_p1, mplier_p1;
  logic [WIDTH-1:0] partial;
  logic [CW-1:0]    cnt_p1;
  logic             last;

  assign last    = (cnt_p1 == CW'(WIDTH - 1));
  assign partial = mplier_p1[0] ? mcand_p1 : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MUL_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      MUL_IDLE: if (start && !abort) state_nx = MUL_RUN;
      MUL_RUN:  if (abort || last)   state_nx = MUL_IDLE;
      default:                       state_nx = MUL_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == MUL_RUN);
    done   = (state == MUL_RUN) && last && !abort;
    result = acc_p1 + partial;
  end

  // Iteration stage: one multiplier bit consumed per cycle while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p1    <= '0;
      mcand_p1  <= '0;
      mplier_p1 <= '0;
      cnt_p1    <= '0;
    end else if (state == MUL_IDLE) begin
      if (start) begin
        acc_p1    <= '0;
        mcand_p1  <= op_a;
        mplier_p1 <= op_b;
        cnt_p1    <= '0;
      end
    end else begin
      acc_p1    <= acc_p1 + partial;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
      cnt_p1    <= cnt_p1 + CW'(1);
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, beq/bne resolution and the EX/MEM register with valid/ready flow.
// Define MULT_EN to add the iterative multiply op (ALU_MUL) through mult_iter.
module ex_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH  = CPU_WIDTH,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  rs_val,
  input  logic [WIDTH-1:0]  rt_val,
  input  logic [WIDTH-1:0]  imm,
  input  logic [REG_AW-1:0] rt_idx,
  input  logic [REG_AW-1:0] rd_idx,
  input  logic              reg_dst,
  input  logic              alu_src,
  input  logic [3:0]        aluo,
  input  logic              is_beq,
  input  logic              is_bne,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [WIDTH-1:0]  out_store_data,
  output logic [REG_AW-1:0] out_wreg,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              branch_taken,
  output logic              busy
);

  function automatic logic [WIDTH-1:0] alu_op(input logic [3:0] op,
                                               input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      ALU_ADD:            r = a + b;
      ALU_SUB:            r = a - b;
      ALU_AND:            r = a & b;
      ALU_OR:             r = a | b;
      ALU_SLT, ALU_SLT_I: r = {{(WIDTH-1){1'b0}}, (a < b)};
      default:            r = '0;
    endcase
    return r;
  endfunction

  logic signed [WIDTH-1:0] a_p0, b_p0;
  logic [WIDTH-1:0]        alu_p0;
  logic [REG_AW-1:0]       wreg_p0;
  logic                    is_branch_p0, taken_p0, wen_p0, accept_p0, is_mul_p0;
  logic                    mul_busy, mul_done;
  logic [WIDTH-1:0]        mul_res;

  logic                    vld_p1, bt_p1, wen_p1, mr_p1, mw_p1;
  logic [WIDTH-1:0]        result_p1, store_p1;
  logic [REG_AW-1:0]       wreg_p1;

  // Execute stage (p0): operand select, ALU and branch compare
  assign a_p0         = $signed(rs_val);
  assign b_p0         = $signed(alu_src ? imm : rt_val);
  assign alu_p0       = alu_op(aluo, a_p0, b_p0);
  assign is_branch_p0 = is_beq || is_bne;
  assign taken_p0     = (is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val));
  assign wreg_p0      = reg_dst ? rd_idx : rt_idx;
  assign wen_p0       = reg_write && !is_branch_p0 && (wreg_p0 != '0);

  assign in_ready  = !mul_busy && (!vld_p1 || out_ready);
  assign accept_p0 = in_valid && in_ready && !flush;

`ifdef MULT_EN
  assign is_mul_p0 = (aluo == ALU_MUL);

  mult_iter #(.WIDTH(WIDTH)) u_mult (
    .clk    (clk),
    .rst    (rst),
    .start  (accept_p0 && is_mul_p0),
    .abort  (flush),
    .op_a   (rs_val),
    .op_b   (b_p0),
    .busy   (mul_busy),
    .done   (mul_done),
    .result (mul_res)
  );
`else
  assign is_mul_p0 = 1'b0;
  assign mul_busy  = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_res   = '0;
`endif

  // EX/MEM register (p1); a multiply latches its side fields at accept and its result at done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      bt_p1     <= 1'b0;
      wen_p1    <= 1'b0;
      mr_p1     <= 1'b0;
      mw_p1     <= 1'b0;
      result_p1 <= '0;
      store_p1  <= '0;
      wreg_p1   <= '0;
    end else begin
      bt_p1 <= 1'b0;
      if (flush) begin
        vld_p1 <= 1'b0;
      end else if (mul_done) begin
        vld_p1    <= 1'b1;
        result_p1 <= mul_res;
      end else if (accept_p0) begin
        store_p1 <= rt_val;
        wreg_p1  <= wreg_p0;
        wen_p1   <= wen_p0;
        mr_p1    <= mem_read;
        mw_p1    <= mem_write;
        if (is_mul_p0) begin
          vld_p1 <= 1'b0;
        end else begin
          vld_p1    <= 1'b1;
          result_p1 <= alu_p0;
          bt_p1     <= taken_p0;
        end
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid      = vld_p1;
  assign out_result     = result_p1;
  assign out_store_data = store_p1;
  assign out_wreg       = wreg_p1;
  assign out_reg_write  = wen_p1;
  assign out_mem_read   = mr_p1;
  assign out_mem_write  = mw_p1;
  assign branch_taken   = bt_p1;
  assign busy           = mul_busy;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, handshake corner sequences,
// and a randomized stream scored against a spec-level reference model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] rs_val, rt_val, imm;
  logic [4:0]  rt_idx, rd_idx;
  logic        reg_dst, alu_src;
  logic [3:0]  aluo;
  logic        is_beq, is_bne, reg_write, mem_read, mem_write, flush;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_store_data;
  logic [4:0]  out_wreg;
  logic        out_reg_write, out_mem_read, out_mem_write, branch_taken, busy;

  int nchecks = 0;
  int nerr    = 0;

  ex_stage #(.WIDTH(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .rt_idx(rt_idx), .rd_idx(rd_idx),
    .reg_dst(reg_dst), .alu_src(alu_src), .aluo(aluo), .is_beq(is_beq), .is_bne(is_bne),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_store_data(out_store_data), .out_wreg(out_wreg), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .branch_taken(branch_taken), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] rs, rt, imm;
    logic [4:0]  rti, rdi;
    logic        rdst, asrc;
    logic [3:0]  op;
    logic        beq, bne, rw, mr, mw;
    logic [31:0] e_res;
    logic [4:0]  e_wreg;
    logic        e_rw, e_bt;
  } vec_t;

  typedef struct {
    logic [31:0] res, store;
    logic [4:0]  wreg;
    logic        rw, mr, mw, bt;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [31:0] rs, rt, im, input logic [4:0] rti, rdi,
                         input logic rdst, asrc, input logic [3:0] op,
                         input logic beq, bne, rw,
                         input logic [31:0] e_res, input logic [4:0] e_wreg,
                         input logic e_rw, e_bt);
    vec_t v;
    v.rs = rs; v.rt = rt; v.imm = im; v.rti = rti; v.rdi = rdi;
    v.rdst = rdst; v.asrc = asrc; v.op = op; v.beq = beq; v.bne = bne; v.rw = rw;
    v.mr = rs[0]; v.mw = rt[0];
    v.e_res = e_res; v.e_wreg = e_wreg; v.e_rw = e_rw; v.e_bt = e_bt;
    vt.push_back(v);
  endtask

  task automatic drive(input logic [31:0] rs, rt, im, input logic [4:0] rti, rdi,
                       input logic rdst, asrc, input logic [3:0] op,
                       input logic beq, bne, rw, mr, mw);
    rs_val = rs; rt_val = rt; imm = im; rt_idx = rti; rd_idx = rdi;
    reg_dst = rdst; alu_src = asrc; aluo = op;
    is_beq = beq; is_bne = bne; reg_write = rw; mem_read = mr; mem_write = mw;
  endtask

  // Reference behaviour computed directly from the instruction semantics
  function automatic exp_t model(input logic [31:0] rs, rt, im, input logic [4:0] rti, rdi,
                                 input logic rdst, asrc, input logic [3:0] op,
                                 input logic beq, bne, rw, mr, mw);
    exp_t e;
    logic [31:0] b;
    int signed sa, sb_;
    b = asrc ? im : rt;
    sa = rs; sb_ = b;
    case (op)
      4'd0:        e.res = rs + b;
      4'd1:        e.res = rs - b;
      4'd2:        e.res = rs & b;
      4'd3:        e.res = rs | b;
      4'd7, 4'd15: e.res = (sa < sb_) ? 32'd1 : 32'd0;
      default:     e.res = 32'd0;
    endcase
    e.store = rt;
    e.wreg  = rdst ? rdi : rti;
    e.bt    = (beq && rs == rt) || (bne && rs != rt);
    e.rw    = rw && !(beq || bne) && (e.wreg != 5'd0);
    e.mr    = mr;
    e.mw    = mw;
    return e;
  endfunction

  task automatic check_all_zero(input string nm);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_result"}, out_result, 0);
    chk({nm, "_store"}, out_store_data, 0);
    chk({nm, "_wreg"}, out_wreg, 0);
    chk({nm, "_rw"}, out_reg_write, 0);
    chk({nm, "_mr"}, out_mem_read, 0);
    chk({nm, "_mw"}, out_mem_write, 0);
    chk({nm, "_bt"}, branch_taken, 0);
    chk({nm, "_busy"}, busy, 0);
  endtask

  initial begin
    exp_t e;
    logic fresh;
    logic exp_ready, acc;
    logic [31:0] r_rs, r_rt, r_imm;
    logic [4:0]  r_rti, r_rdi;
    logic [3:0]  r_op;
    logic        r_rdst, r_asrc, r_beq, r_bne, r_rw, r_mr, r_mw;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Directed table: rs, rt, imm, rt_idx, rd_idx, reg_dst, alu_src, op, beq, bne, rw, exp...
    add_vec(5, 7, 0, 9, 3, 1, 0, 4'b0000, 0, 0, 1, 12, 3, 1, 0);
    add_vec(32'hFFFF_FFFF, 0, 1, 4, 6, 0, 1, 4'b1111, 0, 0, 1, 1, 4, 1, 0);
    add_vec(0, 1, 0, 2, 8, 1, 0, 4'b0001, 0, 0, 1, 32'hFFFF_FFFF, 8, 1, 0);
    add_vec(4, 4, 0, 0, 5, 1, 0, 4'b0001, 0, 1, 1, 0, 5, 0, 0);
    add_vec(4, 4, 99, 0, 5, 1, 1, 4'b0001, 1, 0, 1, 32'hFFFF_FFA1, 5, 0, 1);
    add_vec(32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 7, 0, 0, 0, 4'b0010, 0, 0, 1, 32'h00F0_000F, 7, 1, 0);
    add_vec(32'hF000_0000, 0, 32'h0000_00AA, 7, 0, 0, 1, 4'b0011, 0, 0, 1, 32'hF000_00AA, 7, 1, 0);
    add_vec(3, 2, 0, 1, 0, 1, 0, 4'b0111, 0, 0, 1, 0, 0, 0, 0);
    add_vec(3, 2, 0, 1, 0, 0, 0, 4'b0101, 0, 0, 1, 0, 1, 1, 0);
    add_vec(1, 2, 0, 1, 0, 0, 0, 4'b0000, 1, 0, 1, 3, 1, 0, 0);
`ifndef MULT_EN
    add_vec(3, 5, 0, 1, 0, 0, 0, 4'b1000, 0, 0, 1, 0, 1, 1, 0);
`endif

    foreach (vt[i]) begin
      chk("vec_in_ready", in_ready, 1);
      drive(vt[i].rs, vt[i].rt, vt[i].imm, vt[i].rti, vt[i].rdi, vt[i].rdst, vt[i].asrc,
            vt[i].op, vt[i].beq, vt[i].bne, vt[i].rw, vt[i].mr, vt[i].mw);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("vec_valid", out_valid, 1);
      chk("vec_result", out_result, vt[i].e_res);
      chk("vec_wreg", out_wreg, vt[i].e_wreg);
      chk("vec_rw", out_reg_write, vt[i].e_rw);
      chk("vec_bt", branch_taken, vt[i].e_bt);
      chk("vec_store", out_store_data, vt[i].rt);
      chk("vec_mr", out_mem_read, vt[i].mr);
      chk("vec_mw", out_mem_write, vt[i].mw);
      tick();
      chk("vec_drain", out_valid, 0);
      chk("vec_bt_pulse", branch_taken, 0);
    end

    // Backpressure: held item stays put while a new one waits, then reloads with no bubble
    out_ready = 1'b0;
    drive(1, 2, 0, 0, 4, 1, 0, 4'b0000, 0, 0, 1, 0, 0);
    in_valid = 1'b1;
    tick();
    drive(10, 20, 0, 0, 6, 1, 0, 4'b0000, 0, 0, 1, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_hold_result", out_result, 3);
      chk("bp_hold_wreg", out_wreg, 4);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_nobubble_valid", out_valid, 1);
    chk("bp_nobubble_result", out_result, 30);
    chk("bp_nobubble_wreg", out_wreg, 6);
    tick();
    chk("bp_drain", out_valid, 0);

    // Flush with a held item and an incoming one
    out_ready = 1'b0;
    drive(1, 2, 0, 0, 4, 1, 0, 4'b0000, 1, 0, 1, 0, 0);
    in_valid = 1'b1;
    tick();
    chk("fl_pre_valid", out_valid, 1);
    drive(7, 7, 0, 0, 4, 1, 0, 4'b0000, 1, 0, 1, 0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_bt", branch_taken, 0);
    tick();
    chk("fl_nothing_accepted", out_valid, 0);
    out_ready = 1'b1;

    // Asynchronous reset mid-stream
    drive(32'h1234, 32'h5679, 0, 0, 9, 1, 0, 4'b0000, 0, 0, 1, 1, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rst_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    tick();
    rst = 1'b0;
    tick();

`ifdef MULT_EN
    // Multiply: busy for WIDTH cycles, result on cycle WIDTH+1
    drive(3, 32'h0001_0000, 0, 0, 2, 1, 0, 4'b1000, 0, 0, 1, 0, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      chk("mul_busy", busy, 1);
      chk("mul_no_valid", out_valid, 0);
      chk("mul_in_ready", in_ready, 0);
      tick();
    end
    chk("mul_busy_end", busy, 0);
    chk("mul_valid", out_valid, 1);
    chk("mul_result", out_result, 32'h0003_0000);
    chk("mul_wreg", out_wreg, 2);
    tick();

    // Flush at cycle 10 aborts the multiply
    drive(3, 32'h0001_0000, 0, 0, 2, 1, 0, 4'b1000, 0, 0, 1, 0, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    chk("mulfl_busy", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("mulfl_busy_cleared", busy, 0);
    for (int c = 0; c < 40; c++) begin
      if (out_valid !== 1'b0) chk("mulfl_no_valid", out_valid, 0);
      tick();
    end
    chk("mulfl_final_valid", out_valid, 0);

    // Reset mid-multiply also aborts it
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check_all_zero("mulrst");
    tick();
    rst = 1'b0;
    for (int c = 0; c < 40; c++) tick();
    chk("mulrst_no_valid", out_valid, 0);
`endif

    // Randomized stream against the reference model
    fresh = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      chk("rnd_valid", out_valid, (sb.size() != 0));
      if (sb.size() != 0 && out_valid) begin
        e = sb[0];
        chk("rnd_result", out_result, e.res);
        chk("rnd_store", out_store_data, e.store);
        chk("rnd_wreg", out_wreg, e.wreg);
        chk("rnd_rw", out_reg_write, e.rw);
        chk("rnd_mr", out_mem_read, e.mr);
        chk("rnd_mw", out_mem_write, e.mw);
        chk("rnd_bt", branch_taken, e.bt && fresh);
      end else begin
        chk("rnd_bt_idle", branch_taken, 0);
      end
      fresh = 1'b0;

      r_rs  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      r_rt  = ($urandom_range(0, 2) == 0) ? r_rs : $urandom;
      r_imm = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed(4'($urandom)));
      r_rti = 5'($urandom); r_rdi = 5'($urandom);
      r_rdst = 1'($urandom); r_asrc = 1'($urandom);
      r_op = 4'($urandom);
      if ($urandom_range(0, 1) == 0) r_op = ($urandom_range(0, 1) == 0) ? 4'd7 : 4'd1;
`ifdef MULT_EN
      if (r_op == 4'd8) r_op = 4'd0;
`endif
      r_beq = ($urandom_range(0, 4) == 0);
      r_bne = !r_beq && ($urandom_range(0, 4) == 0);
      r_rw = 1'($urandom); r_mr = 1'($urandom); r_mw = 1'($urandom);
      drive(r_rs, r_rt, r_imm, r_rti, r_rdi, r_rdst, r_asrc, r_op, r_beq, r_bne, r_rw, r_mr, r_mw);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      exp_ready = (sb.size() == 0) || out_ready;
      chk("rnd_in_ready", in_ready, exp_ready);
      acc = in_valid && exp_ready && !flush;
      if (sb.size() != 0 && out_ready) void'(sb.pop_front());
      if (flush) begin
        sb.delete();
      end else if (acc) begin
        sb.push_back(model(r_rs, r_rt, r_imm, r_rti, r_rdi, r_rdst, r_asrc, r_op,
                           r_beq, r_bne, r_rw, r_mr, r_mw));
        fresh = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
